// File: rtl/mem_write_checker.sv
// Store-bus checker: compares processor writes against a preloaded table of
// expected {address, data} pairs in order, flagging mismatches and timeouts.
module mem_write_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 1000,
  parameter int STRICT     = 0,
  parameter int IGNORE_ADR = 96,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [31:0]       cyc_cnt,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_DATA = 2'd1;
  localparam logic [1:0] FC_UNEX = 2'd2;
  localparam logic [1:0] FC_TOUT = 2'd3;

  state_e            state_q, state_d;
  entry_t            tbl_q [DEPTH];
  logic [CNT_W-1:0]  match_q, match_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] fadr_q, fadr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [IDX_W-1:0]  cur_idx;
  entry_t            cur;
  logic              hit_adr, hit_data, last, tout, unexp;

  // Index is only meaningful while match_cnt < DEPTH (i.e. in RUN).
  assign cur_idx  = (32'(match_q) < DEPTH) ? match_q[IDX_W-1:0] : '0;
  assign cur      = tbl_q[cur_idx];
  assign hit_adr  = MemWrite && (Adr == cur.adr);
  assign hit_data = hit_adr && (WriteData == cur.data);
  assign last     = (32'(match_q) == DEPTH - 1);
  assign tout     = (cyc_q == 32'(TIMEOUT - 1));
  assign unexp    = (STRICT != 0) && MemWrite && !hit_adr && (Adr != ADDR_W'(IGNORE_ADR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (state_q == IDLE && load_en && 32'(load_idx) < DEPTH) begin
      tbl_q[load_idx] <= {load_adr, load_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      match_q <= '0;
      cyc_q   <= '0;
      code_q  <= FC_NONE;
      fadr_q  <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      cyc_q   <= cyc_d;
      code_q  <= code_d;
      fadr_q  <= fadr_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    cyc_d   = cyc_q;
    code_d  = code_q;
    fadr_d  = fadr_q;
    fdata_d = fdata_q;
    case (state_q)
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        if (hit_data) begin
          match_d = match_q + CNT_W'(1);
          if (last) begin
            state_d = PASS;
          end else if (tout) begin
            state_d = FAIL;
            code_d  = FC_TOUT;
            fadr_d  = '0;
            fdata_d = '0;
          end
        end else if (hit_adr || unexp) begin
          state_d = FAIL;
          code_d  = hit_adr ? FC_DATA : FC_UNEX;
          fadr_d  = Adr;
          fdata_d = WriteData;
        end else if (tout) begin
          state_d = FAIL;
          code_d  = FC_TOUT;
          fadr_d  = '0;
          fdata_d = '0;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          match_d = '0;
          cyc_d   = '0;
          code_d  = FC_NONE;
          fadr_d  = '0;
          fdata_d = '0;
        end
      end
    endcase
  end

  assign done      = (state_q == PASS) || (state_q == FAIL);
  assign pass      = (state_q == PASS);
  assign fail_code = code_q;
  assign match_cnt = match_q;
  assign cyc_cnt   = cyc_q;
  assign fail_adr  = fadr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: three checker instances (lenient, strict/short timeout,
// three-entry) sharing one store bus, each with its own load enable and start.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  st = '0;
  logic [2:0]  le = '0;
  logic [1:0]  load_idx = '0;
  logic [31:0] load_adr = '0, load_data = '0;
  logic        we = 1'b0;
  logic [31:0] adr = '0, wdata = '0;

  logic        done0, pass0, done1, pass1, done2, pass2;
  logic [1:0]  code0, code1, code2;
  logic [0:0]  mc0, mc1;
  logic [1:0]  mc2;
  logic [31:0] cyc0, cyc1, cyc2, fa0, fa1, fa2, fd0, fd1, fd2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.DEPTH(1), .TIMEOUT(1000), .STRICT(0)) u0 (
    .clk(clk), .reset(reset), .start(st[0]), .load_en(le[0]), .load_idx(load_idx[0:0]),
    .load_adr(load_adr), .load_data(load_data), .MemWrite(we), .Adr(adr), .WriteData(wdata),
    .done(done0), .pass(pass0), .fail_code(code0), .match_cnt(mc0), .cyc_cnt(cyc0),
    .fail_adr(fa0), .fail_data(fd0));

  mem_write_checker #(.DEPTH(1), .TIMEOUT(20), .STRICT(1)) u1 (
    .clk(clk), .reset(reset), .start(st[1]), .load_en(le[1]), .load_idx(load_idx[0:0]),
    .load_adr(load_adr), .load_data(load_data), .MemWrite(we), .Adr(adr), .WriteData(wdata),
    .done(done1), .pass(pass1), .fail_code(code1), .match_cnt(mc1), .cyc_cnt(cyc1),
    .fail_adr(fa1), .fail_data(fd1));

  mem_write_checker #(.DEPTH(3), .TIMEOUT(20), .STRICT(0)) u2 (
    .clk(clk), .reset(reset), .start(st[2]), .load_en(le[2]), .load_idx(load_idx),
    .load_adr(load_adr), .load_data(load_data), .MemWrite(we), .Adr(adr), .WriteData(wdata),
    .done(done2), .pass(pass2), .fail_code(code2), .match_cnt(mc2), .cyc_cnt(cyc2),
    .fail_adr(fa2), .fail_data(fd2));

  typedef struct {
    logic        st;
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    logic        done;
    logic        pass;
    logic [1:0]  code;
    logic [31:0] mcnt;
    logic [31:0] cyc;
    logic [31:0] fadr;
    logic [31:0] fdata;
  } vec_t;

  vec_t v [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; adr = a; wdata = d;
  endtask

  task automatic load(input logic [2:0] en, input logic [1:0] idx,
                      input logic [31:0] a, input logic [31:0] d);
    le = en; load_idx = idx; load_adr = a; load_data = d;
    step();
    le = '0;
  endtask

  initial begin
    //       st we adr  data dn ps cd mc cyc fadr fdata
    v[0]  = '{1, 0,   0, 0,  0, 0, 0, 0, 0,   0, 0};
    v[1]  = '{0, 1,  96, 0,  0, 0, 0, 0, 1,   0, 0};
    v[2]  = '{0, 1, 100, 7,  1, 1, 0, 1, 2,   0, 0};
    v[3]  = '{0, 1, 100, 8,  1, 1, 0, 1, 2,   0, 0};
    v[4]  = '{1, 0,   0, 0,  0, 0, 0, 0, 0,   0, 0};
    v[5]  = '{0, 1, 100, 8,  1, 0, 1, 0, 1, 100, 8};
    v[6]  = '{0, 1, 104, 7,  1, 0, 1, 0, 1, 100, 8};
    v[7]  = '{1, 0,   0, 0,  0, 0, 0, 0, 0,   0, 0};
    v[8]  = '{0, 1, 104, 7,  0, 0, 0, 0, 1,   0, 0};
    v[9]  = '{1, 0,   0, 0,  0, 0, 0, 0, 2,   0, 0};
    v[10] = '{0, 1, 100, 7,  1, 1, 0, 1, 3,   0, 0};

    #2;
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_pass", {63'd0, pass0}, 64'd0);
    chk("rst_code", {62'd0, code2}, 64'd0);
    chk("rst_cyc",  {32'd0, cyc2}, 64'd0);
    step();
    reset = 1'b1;
    step();

    load(3'b011, 2'd0, 32'd100, 32'd7);
    load(3'b001, 2'd1, 32'd100, 32'd9);  // out of range for DEPTH=1
    load(3'b100, 2'd0, 32'd0, 32'd1);
    load(3'b100, 2'd1, 32'd4, 32'd2);
    load(3'b100, 2'd2, 32'd8, 32'd3);
    load(3'b100, 2'd3, 32'd12, 32'd9);   // out of range for DEPTH=3

    for (int i = 0; i < 11; i++) begin
      st[0] = v[i].st;
      bus(v[i].we, v[i].adr, v[i].data);
      step();
      chk($sformatf("v%0d_done", i),  {63'd0, done0}, {63'd0, v[i].done});
      chk($sformatf("v%0d_pass", i),  {63'd0, pass0}, {63'd0, v[i].pass});
      chk($sformatf("v%0d_code", i),  {62'd0, code0}, {62'd0, v[i].code});
      chk($sformatf("v%0d_mcnt", i),  {63'd0, mc0},   {32'd0, v[i].mcnt});
      chk($sformatf("v%0d_cyc", i),   {32'd0, cyc0},  {32'd0, v[i].cyc});
      chk($sformatf("v%0d_fadr", i),  {32'd0, fa0},   {32'd0, v[i].fadr});
      chk($sformatf("v%0d_fdata", i), {32'd0, fd0},   {32'd0, v[i].fdata});
    end
    st[0] = 1'b0;
    bus(0, 0, 0);

    // Strict mode: unexpected address fails with code 2
    st[1] = 1'b1; step(); st[1] = 1'b0;
    bus(1, 104, 7); step(); bus(0, 0, 0);
    chk("unex_done", {63'd0, done1}, 64'd1);
    chk("unex_code", {62'd0, code1}, 64'd2);
    chk("unex_fadr", {32'd0, fa1}, 64'd104);
    chk("unex_fdata", {32'd0, fd1}, 64'd7);

    // Strict mode: IGNORE_ADR exempt, then timeout at cyc_cnt = 19
    st[1] = 1'b1; step(); st[1] = 1'b0;
    bus(1, 96, 5); step(); bus(0, 0, 0);
    chk("ign_done", {63'd0, done1}, 64'd0);
    repeat (18) step();
    chk("pre_to_done", {63'd0, done1}, 64'd0);
    chk("pre_to_cyc", {32'd0, cyc1}, 64'd19);
    step();
    chk("to_done", {63'd0, done1}, 64'd1);
    chk("to_pass", {63'd0, pass1}, 64'd0);
    chk("to_code", {62'd0, code1}, 64'd3);
    chk("to_fadr", {32'd0, fa1}, 64'd0);
    chk("to_cyc", {32'd0, cyc1}, 64'd20);
    repeat (3) step();
    chk("to_cyc_hold", {32'd0, cyc1}, 64'd20);

    // Data mismatch on the timeout cycle wins over timeout
    st[1] = 1'b1; step(); st[1] = 1'b0;
    repeat (19) step();
    chk("prec_pre_done", {63'd0, done1}, 64'd0);
    bus(1, 100, 8); step(); bus(0, 0, 0);
    chk("prec_code", {62'd0, code1}, 64'd1);
    chk("prec_fadr", {32'd0, fa1}, 64'd100);

    // Three-entry in-order matching with a stray write first
    st[2] = 1'b1; step(); st[2] = 1'b0;
    bus(1, 4, 2); step();
    chk("d3_m0", {62'd0, mc2}, 64'd0);
    bus(1, 0, 1); step();
    chk("d3_m1", {62'd0, mc2}, 64'd1);
    bus(1, 4, 2); step();
    chk("d3_m2", {62'd0, mc2}, 64'd2);
    chk("d3_m2_done", {63'd0, done2}, 64'd0);
    bus(1, 8, 3); step(); bus(0, 0, 0);
    chk("d3_pass", {63'd0, pass2}, 64'd1);
    chk("d3_done", {63'd0, done2}, 64'd1);
    chk("d3_m3", {62'd0, mc2}, 64'd3);

    // Final match on the timeout cycle passes
    st[2] = 1'b1; step(); st[2] = 1'b0;
    bus(1, 0, 1); step();
    bus(1, 4, 2); step(); bus(0, 0, 0);
    repeat (17) step();
    chk("fin_pre_cyc", {32'd0, cyc2}, 64'd19);
    chk("fin_pre_done", {63'd0, done2}, 64'd0);
    bus(1, 8, 3); step(); bus(0, 0, 0);
    chk("fin_pass", {63'd0, pass2}, 64'd1);
    chk("fin_code", {62'd0, code2}, 64'd0);
    chk("fin_m3", {62'd0, mc2}, 64'd3);

    // Asynchronous reset mid-run clears state and table
    st[2] = 1'b1; step(); st[2] = 1'b0;
    bus(1, 0, 1); step(); bus(0, 0, 0);
    chk("mid_m1", {62'd0, mc2}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_m", {62'd0, mc2}, 64'd0);
    chk("arst_cyc", {32'd0, cyc2}, 64'd0);
    chk("arst_done0", {63'd0, done0}, 64'd0);
    chk("arst_code1", {62'd0, code1}, 64'd0);
    chk("arst_fadr1", {32'd0, fa1}, 64'd0);
    step();
    reset = 1'b1;
    bus(1, 0, 1); step(); bus(0, 0, 0);
    chk("post_idle_m", {62'd0, mc2}, 64'd0);
    chk("post_idle_done", {63'd0, done2}, 64'd0);
    st[2] = 1'b1; step(); st[2] = 1'b0;
    bus(1, 0, 1); step(); bus(0, 0, 0);
    chk("clr_code", {62'd0, code2}, 64'd1);
    chk("clr_fadr", {32'd0, fa2}, 64'd0);
    chk("clr_fdata", {32'd0, fd2}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of expected writes (DEPTH >= 1; DEPTH = 0 is illegal).
REQ-004 The block SHALL have parameter TIMEOUT, default 1000, meaning the run-cycle limit before declaring failure.
REQ-005 The block SHALL have parameter STRICT, default 0, meaning: 1 = any unexpected write fails; 0 = unexpected writes are ignored.
REQ-006 The block SHALL have parameter IGNORE_ADR, default 96, meaning an address always exempt from the unexpected-write check.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-009 The block SHALL have port start, input, 1 bit: arms a check run.
REQ-010 The block SHALL have ports load_en (1 bit), load_idx (clog2(DEPTH), min 1 bit), load_adr (ADDR_W), load_data (DATA_W), all inputs: expected-table write port.
REQ-011 The block SHALL have ports MemWrite (1 bit), Adr (ADDR_W), WriteData (DATA_W), all inputs: the monitored processor store bus.
REQ-012 The block SHALL have ports done and pass, outputs, 1 bit each: run finished / run passed.
REQ-013 The block SHALL have port fail_code, output, 2 bits: 0 = none, 1 = data mismatch, 2 = unexpected write, 3 = timeout.
REQ-014 The block SHALL have ports match_cnt (output, clog2(DEPTH+1)), cyc_cnt (output, 32), fail_adr (output, ADDR_W), fail_data (output, DATA_W): progress and diagnostic outputs.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, PASS, FAIL; done = (PASS or FAIL); pass = PASS; all outputs are registered.
REQ-016 In IDLE, load_en = 1 SHALL write {load_adr, load_data} into table entry load_idx at the clock edge; load_en in any other state, and load_idx >= DEPTH, SHALL be ignored.
REQ-017 start = 1 in IDLE, PASS or FAIL SHALL transition to RUN at the next edge and clear match_cnt, cyc_cnt, fail_code, fail_adr and fail_data to 0; start in RUN SHALL be ignored.
REQ-018 In RUN, cyc_cnt SHALL increment by 1 every cycle, saturating at 2^32-1.
REQ-019 In RUN, a cycle with MemWrite = 1, Adr = entry[match_cnt].adr and WriteData = entry[match_cnt].data SHALL increment match_cnt; entries are matched strictly in index order.
REQ-020 The match that makes match_cnt = DEPTH SHALL move the FSM to PASS at that edge, so done = pass = 1 one cycle after the final write is sampled.
REQ-021 A write with MemWrite = 1, Adr = entry[match_cnt].adr and WriteData differing SHALL move the FSM to FAIL with fail_code = 1 and capture fail_adr = Adr, fail_data = WriteData.
REQ-022 With STRICT = 1, a write with MemWrite = 1, Adr != entry[match_cnt].adr and Adr != IGNORE_ADR SHALL move the FSM to FAIL with fail_code = 2, capturing Adr and WriteData.
REQ-023 With STRICT = 0, a write to a non-expected address SHALL be ignored.
REQ-024 If cyc_cnt = TIMEOUT-1 in RUN and that cycle produces no final match, the FSM SHALL move to FAIL with fail_code = 3 and fail_adr = fail_data = 0.
REQ-025 Precedence in the same cycle SHALL be: final match > data mismatch / unexpected write > timeout.
REQ-026 PASS and FAIL SHALL be sticky until start or reset; MemWrite activity in those states SHALL be ignored, and cyc_cnt and match_cnt SHALL hold.

Reset
REQ-027 reset = 0 SHALL immediately, without a clock, force IDLE, all outputs to 0, and all table entries to 0.
REQ-028 Deassertion of reset SHALL take effect at the first rising clk edge with reset = 1; a run interrupted by reset SHALL require a new start.

Verification
REQ-029 DEPTH=1, table {100,7}, start, writes (96,0) then (100,7) -> next cycle done=1, pass=1, match_cnt=1, fail_code=0.
REQ-030 Same table, write (100,8) -> done=1, pass=0, fail_code=1, fail_adr=100, fail_data=8.
REQ-031 STRICT=1, write (104,7) -> fail_code=2, fail_adr=104; with STRICT=0 the same write -> FSM stays in RUN, match_cnt=0.
REQ-032 TIMEOUT=20, no writes after start -> FAIL, fail_code=3 on the edge where cyc_cnt=19; cyc_cnt then holds.
REQ-033 DEPTH=3, table {(0,1),(4,2),(8,3)}: writes (4,2),(0,1),(4,2),(8,3) with STRICT=0 -> pass=1, match_cnt=3; with the final write sampled in the same cycle as cyc_cnt=TIMEOUT-1 -> PASS.
REQ-034 Mid-RUN with match_cnt=1, reset=0 pulse -> outputs 0 asynchronously, table cleared; later writes ignored until reload and start.
